// File: rtl/cpu_pkg.sv
// Shared definitions for the IF-stage instruction-RAM loader: state encoding
// and the default restart vector.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_LOAD   = 2'd2,
        S_RESUME = 2'd3
    } ld_state_t;

    localparam logic [31:0] DEF_RESTART_PC = 32'h0000_0000;

    // Wide enough for the largest legal drain length (15 cycles).
    localparam int DRAIN_W = 4;

endpackage

// File: rtl/if_load_csum.sv
// Checksum accumulator for a load session: 32-bit wrapping sum of every
// accepted loader word, cleared at session start and on reset.
module if_load_csum (
    input  logic        clk,
    input  logic        clrn,
    input  logic        clear,
    input  logic        acc,
    input  logic [31:0] data,
    output logic [31:0] csum
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            csum <= '0;
        end else if (clear) begin
            csum <= '0;
        end else if (acc) begin
            csum <= csum + data;
        end
    end

endmodule

// File: rtl/if_imem_loader.sv
// IF-stage instruction-RAM arbiter: fetch owns the RAM until an external
// loader asks for it; the pipeline is then stalled, drained, the loader streams
// words in, and fetch restarts at RESTART_PC.
// Build option: define IF_LOAD_CHK_EN to build the load checksum (ld_csum);
// otherwise ld_csum is tied to zero.
module if_imem_loader
    import cpu_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter int          DRAIN_CYC  = 2,
    parameter logic [31:0] RESTART_PC = DEF_RESTART_PC
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [31:0]       pc,
    input  logic              ld_req,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              if_stall,
    output logic              pc_restart,
    output logic [31:0]       restart_pc,
    output logic [ADDR_W:0]   ld_count,
    output logic [31:0]       ld_csum
);

    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    ld_state_t          state, state_nxt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               start;
    logic               accept;

    // Only the word-address bits of the PC reach the RAM.
    logic unused_pc;
    assign unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

    assign restart_pc = RESTART_PC;
    assign start      = (state == S_RUN) && ld_req;
    assign accept     = (state == S_LOAD) && ld_valid;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= S_RUN;
            drain_cnt <= '0;
            ld_count  <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                drain_cnt <= DRAIN_W'(DRAIN_CYC - 1);
                ld_count  <= '0;
            end else begin
                if ((state == S_DRAIN) && (drain_cnt != '0)) begin
                    drain_cnt <= drain_cnt - 1'b1;
                end
                if (accept && (ld_count != CNT_MAX)) begin
                    ld_count <= ld_count + 1'b1;
                end
            end
        end
    end

    // NOTE: every output and state_nxt gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt  = state;
        ld_ready   = 1'b0;
        ram_ena    = 1'b1;
        ram_wena   = 1'b0;
        ram_addr   = pc[ADDR_W+1:2];
        ram_wdata  = '0;
        if_stall   = 1'b0;
        pc_restart = 1'b0;

        case (state)
            S_RUN: begin
                if (ld_req) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if_stall = 1'b1;
                ram_ena  = 1'b0;
                if (!ld_req) begin
                    state_nxt = S_RUN;
                end else if (drain_cnt == '0) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if_stall  = 1'b1;
                ld_ready  = 1'b1;
                ram_addr  = ld_addr;
                ram_wdata = ld_data;
                ram_ena   = ld_valid;
                ram_wena  = ld_valid;
                // A word arriving as the request drops is still written, and
                // counts as a non-empty session.
                if (ld_valid && (ld_last || !ld_req)) begin
                    state_nxt = S_RESUME;
                end else if (!ld_req) begin
                    state_nxt = (ld_count != '0) ? S_RESUME : S_RUN;
                end
            end
            S_RESUME: begin
                if_stall   = 1'b1;
                pc_restart = 1'b1;
                ram_addr   = RESTART_PC[ADDR_W+1:2];
                state_nxt  = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

`ifdef IF_LOAD_CHK_EN
    if_load_csum u_csum (
        .clk   (clk),
        .clrn  (clrn),
        .clear (start),
        .acc   (accept),
        .data  (ld_data),
        .csum  (ld_csum)
    );
`else
    assign ld_csum = 32'h0;
`endif

endmodule

// File: tb/tb_if_imem_loader.sv
// Directed self-checking bench for if_imem_loader (default parameters).
module tb_if_imem_loader;

    localparam int ADDR_W = 10;

`ifdef IF_LOAD_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk;
    logic              clrn;
    logic [31:0]       pc;
    logic              ld_req;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ram_ena;
    logic              ram_wena;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              if_stall;
    logic              pc_restart;
    logic [31:0]       restart_pc;
    logic [ADDR_W:0]   ld_count;
    logic [31:0]       ld_csum;

    int n_checks = 0;
    int n_errors = 0;

    if_imem_loader #(
        .ADDR_W     (ADDR_W),
        .DRAIN_CYC  (2),
        .RESTART_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .pc         (pc),
        .ld_req     (ld_req),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ram_ena    (ram_ena),
        .ram_wena   (ram_wena),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .if_stall   (if_stall),
        .pc_restart (pc_restart),
        .restart_pc (restart_pc),
        .ld_count   (ld_count),
        .ld_csum    (ld_csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_csum(input logic [31:0] v);
        return CHK_EN ? v : 32'h0;
    endfunction

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Raise ld_req in RUN and step through the two DRAIN cycles into LOAD.
    task automatic enter_load();
        ld_req = 1'b1;
        repeat (3) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        clrn = 1'b0; pc = 32'h0; ld_req = 1'b0; ld_valid = 1'b0;
        ld_addr = '0; ld_data = '0; ld_last = 1'b0;
        #1;
        check("rst_ena",     ram_ena, 1);
        check("rst_wena",    ram_wena, 0);
        check("rst_stall",   if_stall, 0);
        check("rst_restart", pc_restart, 0);
        check("rst_ready",   ld_ready, 0);
        check("rst_count",   ld_count, 0);
        check("rst_csum",    ld_csum, 0);
        check("restart_pc",  restart_pc, 32'h0);
        #20 clrn = 1'b1;
        cyc();

        // Fetch path in RUN.
        pc = 32'h0000_0010; #1;
        check("run_addr",  ram_addr, 4);
        check("run_ena",   ram_ena, 1);
        check("run_wena",  ram_wena, 0);
        check("run_stall", if_stall, 0);

        // Session 1: drain timing, three words, last on the third.
        ld_req = 1'b1; #1;
        check("t0_stall", if_stall, 0);
        cyc();
        check("t1_stall", if_stall, 1);
        check("t1_ena",   ram_ena, 0);
        check("t1_ready", ld_ready, 0);
        cyc();
        check("t2_ready", ld_ready, 0);
        check("t2_stall", if_stall, 1);
        cyc();
        check("t3_ready", ld_ready, 1);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_addr = ADDR_W'(i); ld_data = 32'(i + 1);
            ld_last = (i == 2); #1;
            check("s1_wena",  ram_wena, 1);
            check("s1_ena",   ram_ena, 1);
            check("s1_addr",  ram_addr, i);
            check("s1_wdata", ram_wdata, i + 1);
            cyc();
        end
        ld_valid = 1'b0; ld_last = 1'b0; pc = 32'h0; #1;
        check("s1_restart",  pc_restart, 1);
        check("s1_res_stall", if_stall, 1);
        check("s1_res_wena", ram_wena, 0);
        check("s1_res_ena",  ram_ena, 1);
        check("s1_res_addr", ram_addr, 0);
        check("s1_count",    ld_count, 3);
        check("s1_csum",     ld_csum, exp_csum(32'h6));
        // ld_req still high in RESUME is ignored; RUN follows for one cycle.
        cyc();
        check("s1_run_restart", pc_restart, 0);
        check("s1_run_stall",   if_stall, 0);
        check("s1_run_addr",    ram_addr, 0);
        check("s1_run_count",   ld_count, 3);
        check("s1_run_csum",    ld_csum, exp_csum(32'h6));

        // Session 2: re-entered DRAIN, aborted by dropping ld_req.
        cyc();
        check("s2_drain_stall", if_stall, 1);
        check("s2_drain_count", ld_count, 0);
        check("s2_drain_csum",  ld_csum, 0);
        ld_req = 1'b0;
        cyc();
        check("s2_run_stall",   if_stall, 0);
        check("s2_run_restart", pc_restart, 0);
        check("s2_run_wena",    ram_wena, 0);
        cyc();
        check("s2_run2_restart", pc_restart, 0);
        check("s2_run2_stall",   if_stall, 0);

        // Session 3: one word, loader idle 5 cycles, then ld_req drops.
        pc = 32'h0000_0020;
        enter_load();
        ld_valid = 1'b1; ld_addr = 10'd5; ld_data = 32'hA5A5_0001; #1;
        check("s3_wena", ram_wena, 1);
        cyc();
        ld_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("s3_idle_wena",  ram_wena, 0);
            check("s3_idle_stall", if_stall, 1);
            check("s3_idle_ready", ld_ready, 1);
            cyc();
        end
        ld_req = 1'b0; #1;
        check("s3_drop_wena", ram_wena, 0);
        cyc();
        check("s3_restart", pc_restart, 1);
        check("s3_count",   ld_count, 1);
        check("s3_csum",    ld_csum, exp_csum(32'hA5A5_0001));
        cyc();
        check("s3_run_stall", if_stall, 0);
        check("s3_run_addr",  ram_addr, 8);

        // Session 4: ld_req drops with ld_valid high -> word written, RESUME.
        enter_load();
        ld_req = 1'b0; ld_valid = 1'b1; ld_addr = 10'd7; ld_data = 32'h9; #1;
        check("s4_wena", ram_wena, 1);
        check("s4_addr", ram_addr, 7);
        cyc();
        ld_valid = 1'b0; #1;
        check("s4_restart", pc_restart, 1);
        check("s4_count",   ld_count, 1);
        cyc();

        // Session 5: ld_req drops in LOAD with nothing written -> RUN, no pulse.
        enter_load();
        ld_req = 1'b0;
        cyc();
        check("s5_restart", pc_restart, 0);
        check("s5_stall",   if_stall, 0);
        check("s5_count",   ld_count, 0);

        // Session 6: count saturation and checksum wrap.
        enter_load();
        for (int i = 0; i < 1030; i++) begin
            ld_valid = 1'b1; ld_addr = i[ADDR_W-1:0];
            ld_data = (i == 0) ? 32'hFFFF_FFFF : 32'h1;
            cyc();
            if (i == 1022) check("s6_count_1023", ld_count, 1023);
            if (i == 1023) check("s6_count_1024", ld_count, 1024);
        end
        ld_valid = 1'b0; ld_req = 1'b0; #1;
        check("s6_count_sat", ld_count, 1024);
        cyc();
        check("s6_restart", pc_restart, 1);
        check("s6_csum",    ld_csum, exp_csum(32'h0000_0404));
        cyc();

        // Session 7: asynchronous reset in the middle of LOAD.
        enter_load();
        ld_valid = 1'b1; ld_addr = 10'd3; ld_data = 32'h33;
        cyc();
        check("s7_count", ld_count, 1);
        #1;
        check("s7_wena_pre", ram_wena, 1);
        clrn = 1'b0; #1;
        check("s7_wena",  ram_wena, 0);
        check("s7_stall", if_stall, 0);
        check("s7_ready", ld_ready, 0);
        check("s7_ena",   ram_ena, 1);
        check("s7_count_rst", ld_count, 0);
        check("s7_csum_rst",  ld_csum, 0);
        ld_req = 1'b0; ld_valid = 1'b0;
        #10 clrn = 1'b1;
        cyc();
        check("s7_run_stall", if_stall, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_imem_loader.md
Name: if_imem_loader

Overview:
- Controls the shared instruction RAM in the IF stage.
- In normal operation, fetch owns the RAM and reads at pc[ADDR_W+1:2].
- On request, an external program loader takes the RAM. The block stalls the pipeline, drains the in-flight fetch, streams words into the RAM over a valid/ready handshake, then restarts fetch at a fixed vector.
- Drives the RAM's ena/wena/addr/wdata pins and the pipeline stall/restart controls.

Parameters:
- ADDR_W, 10, RAM word-address width (RAM depth 2^ADDR_W words).
- DRAIN_CYC, 2, cycles spent in DRAIN before loading starts; legal range 1..15.
- RESTART_PC, 32'h0000_0000, PC value forced after a load.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- pc  in  32  current fetch PC.
- ld_req  in  1  loader requests RAM ownership; level, held for the whole session.
- ld_valid  in  1  loader word valid.
- ld_addr  in  ADDR_W  word address of the loader word.
- ld_data  in  32  loader word.
- ld_last  in  1  qualifies the final word of the session.
- ld_ready  out  1  block accepts a loader word.
- ram_ena  out  1  RAM enable.
- ram_wena  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- if_stall  out  1  freeze PC and the IF/ID register.
- pc_restart  out  1  one-cycle pulse: load restart_pc into the PC.
- restart_pc  out  32  constant RESTART_PC.
- ld_count  out  ADDR_W+1  words accepted in the current or most recent session.
- ld_csum  out  32  load checksum (see Optional Feature).

Behaviour:
- States are RUN, DRAIN, LOAD, RESUME. Outputs are Moore-decoded from the state, except the write path in LOAD.
- Reset (clrn low, asynchronous): state=RUN, drain counter=0, ld_count=0, ld_csum=0. Any write in progress stops immediately. Outputs under reset are the RUN decode: ram_ena=1, ram_wena=0, if_stall=0, pc_restart=0, ld_ready=0.
- RUN:
  - ram_ena=1, ram_wena=0, ram_addr=pc[ADDR_W+1:2], if_stall=0.
  - If ld_req is sampled high, go to DRAIN: load the drain counter with DRAIN_CYC-1 and clear ld_count and ld_csum.
- DRAIN:
  - if_stall=1, ram_ena=0, ld_ready=0.
  - The counter decrements each cycle. At 0, go to LOAD, so exactly DRAIN_CYC cycles are spent in DRAIN.
  - If ld_req drops during DRAIN, go to RUN; no restart pulse.
- LOAD:
  - if_stall=1, ld_ready=1.
  - ram_addr=ld_addr and ram_wdata=ld_data.
  - ram_ena = ram_wena = ld_valid (combinational, same cycle as acceptance).
  - Each accepted word (ld_valid & ld_ready) increments ld_count.
  - An accepted word with ld_last set goes to RESUME.
  - If ld_req drops with no transfer that cycle: go to RESUME if ld_count != 0, else to RUN.
  - If ld_req drops and ld_valid is high in the same cycle, the word is written and the state goes to RESUME.
- RESUME (exactly 1 cycle):
  - pc_restart=1, if_stall=1.
  - ram_ena=1, ram_wena=0, ram_addr=RESTART_PC[ADDR_W+1:2].
  - Always goes to RUN next.
- ld_count saturates at 2^ADDR_W; it never wraps. Address wrap is the loader's concern; ld_addr is written as given.
- Simultaneous ld_req and restart: ld_req high in RESUME is ignored. It is sampled again in RUN, so the minimum gap between sessions is one RUN cycle.
- ld_count and ld_csum hold their values in RUN until the next session starts.

Optional Feature:
- Macro: IF_LOAD_CHK_EN.
- Defined: ld_csum is a 32-bit wrapping sum (modulo 2^32) of every accepted ld_data in the session. It is cleared on entry to DRAIN and on reset.
- Undefined: the checksum register is not built and ld_csum is tied to 32'h0.

Decomposition:
- Shared package (cpu_pkg): state encoding constants S_RUN=2'd0, S_DRAIN=2'd1, S_LOAD=2'd2, S_RESUME=2'd3; default RESTART_PC.
- One natural sub-module: if_load_csum, the checksum accumulator, instantiated only under IF_LOAD_CHK_EN.

Test Plan:
- Reset, then pc=32'h0000_0010 in RUN -> ram_addr=4, ram_ena=1, ram_wena=0, if_stall=0.
- ld_req rises at cycle t with DRAIN_CYC=2 -> if_stall=1 from t+1; ld_ready=1 first at t+3.
- Write 3 words to addresses 0,1,2 (data 32'h1,32'h2,32'h3), ld_last on the third -> three wena pulses, then one pc_restart pulse; ld_count=3; ld_csum=32'h6 (0 without the macro); RUN with ram_addr=0.
- ld_req dropped during DRAIN -> return to RUN, no pc_restart, no writes.
- Loader stalls (ld_valid=0) for 5 cycles mid-session -> no writes, if_stall held at 1. Then ld_req drops with ld_count=1 -> RESUME pulse.
- clrn pulsed low mid-LOAD with ld_valid=1 -> ram_wena=0 immediately, state RUN, ld_count=0, if_stall=0.
